// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with a small first-word-fall-through FIFO.
//               RXD is double-flopped, the start bit is validated at mid-bit,
//               data bits are sampled once per bit period (LSB first) and each
//               byte with a good stop bit is pushed into the FIFO. Framing and
//               overrun errors are reported through sticky flags.
// Ports       : clk        - system clock
//               reset      - synchronous active-high reset
//               rxd        - asynchronous serial input, idle high
//               rd_en      - pop request (ignored while rd_valid=0)
//               rd_data    - FIFO head byte, valid while rd_valid=1
//               rd_valid   - FIFO not empty
//               fifo_full  - FIFO holds FIFO_DEPTH bytes
//               frame_err  - sticky: stop bit sampled low
//               overrun    - sticky: good byte dropped, FIFO was full
//               err_clr    - clears both sticky flags (a same-cycle set wins)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       rd_en,
    input  logic       err_clr,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       fifo_full,
    output logic       frame_err,
    output logic       overrun
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_HALF   = CLKS_PER_BIT / 2;
    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_CNTF_W = c_PTR_W + 1;

    localparam logic [c_CNT_W-1:0]  c_HALF_M1  = c_CNT_W'(c_HALF - 1);
    localparam logic [c_CNT_W-1:0]  c_BIT_END  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ZERO = '0;
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNTF_W-1:0] c_CNTF_ONE = c_CNTF_W'(1);
    localparam logic [c_CNTF_W-1:0] c_FULL     = c_CNTF_W'(FIFO_DEPTH);
    localparam logic [2:0]          c_LAST_BIT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic               r_sync1;
    logic               r_sync2;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNTF_W-1:0] r_count;
    logic [7:0]          r_rd_data;
    logic                r_frame_err;
    logic                r_overrun;

    logic                w_rx_s;
    logic                w_stop_smp;
    logic                w_push;
    logic                w_ferr_set;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_wr;
    logic                w_ovr_set;
    logic [c_PTR_W-1:0]  w_rd_ptr_nxt;
    logic [c_CNTF_W-1:0] w_count_nxt;

    // ------------------------------------------------------------------------
    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rx_s = r_sync2;

    // ------------------------------------------------------------------------
    // Receive FSM. The counter restarts at every state entry and every
    // sample point, so each sample lands one full bit period after the last.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= c_CNT_ZERO;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= c_CNT_ZERO;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == c_HALF_M1) begin
                        r_cnt     <= c_CNT_ZERO;
                        r_bit_idx <= 3'd0;
                        // A line that is high again at mid-start was a glitch.
                        r_state   <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (r_cnt == c_BIT_END) begin
                        r_cnt   <= c_CNT_ZERO;
                        r_shift <= {w_rx_s, r_shift[7:1]};
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (r_cnt == c_BIT_END) begin
                        // Back to IDLE at mid-stop-bit so a back-to-back
                        // start edge is still caught.
                        r_cnt   <= c_CNT_ZERO;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= c_CNT_ZERO;
                end
            endcase
        end
    end

    assign w_stop_smp = (r_state == S_STOP) && (r_cnt == c_BIT_END);
    assign w_push     = w_stop_smp & w_rx_s;
    assign w_ferr_set = w_stop_smp & ~w_rx_s;

    // ------------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------------
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_FULL);
    assign w_pop   = rd_en & ~w_empty;
    // When full, a same-cycle pop frees the slot the push needs.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovr_set = w_push & w_full & ~w_pop;

    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + c_PTR_ONE) : r_rd_ptr;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNTF_ONE;
            2'b01:   w_count_nxt = r_count - c_CNTF_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            r_rd_ptr <= w_rd_ptr_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Registered head. If the slot becoming the head is being written this
    // cycle, the memory still holds stale data, so forward the incoming byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= 8'h00;
        end else if (w_wr && (r_wr_ptr == w_rd_ptr_nxt)) begin
            r_rd_data <= r_shift;
        end else if (w_count_nxt != '0) begin
            r_rd_data <= r_mem[w_rd_ptr_nxt];
        end
    end

    // ------------------------------------------------------------------------
    // Sticky error flags; a set in the same cycle as err_clr wins.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= w_ferr_set | (r_frame_err & ~err_clr);
            r_overrun   <= w_ovr_set  | (r_overrun   & ~err_clr);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rd_data   = r_rd_data;
    assign rd_valid  = ~w_empty;
    assign fifo_full = w_full;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo. Serial frames
//               are driven on rxd; every good byte sent is queued as the
//               expected FIFO output and compared when popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CLKS_PER_BIT = 217;
    localparam int FIFO_DEPTH   = 4;
    localparam int c_LAT        = 2064;

    logic       clk;
    logic       reset;
    logic       rxd;
    logic       rd_en;
    logic       err_clr;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       fifo_full;
    logic       frame_err;
    logic       overrun;

    int         checks;
    int         errors;
    int         cyc;
    int         t_start;
    int         lat_first;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rxd      (rxd),
        .rd_en    (rd_en),
        .err_clr  (err_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .fifo_full(fifo_full),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock step; inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (lat_first < 0 && rd_valid === 1'b1) lat_first = cyc - t_start;
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        step();
        t_start   = cyc;
        lat_first = -1;
        rxd       = 1'b0;
        repeat (CLKS_PER_BIT - 1) step();
        for (int i = 0; i < 8; i++) begin
            step();
            rxd = b[i];
            repeat (CLKS_PER_BIT - 1) step();
        end
        step();
        rxd = stop_val;
        repeat (CLKS_PER_BIT - 1) step();
        step();
        rxd = 1'b1;
    endtask

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=pop expected=empty_scoreboard", tag);
        end else begin
            exp = exp_q.pop_front();
            check({tag, "_data"}, {24'd0, rd_data}, {24'd0, exp});
        end
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_valid"},  {31'd0, rd_valid},  32'd0);
        check({tag, "_fifo_full"}, {31'd0, fifo_full}, 32'd0);
        check({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
        check({tag, "_overrun"},   {31'd0, overrun},   32'd0);
        check({tag, "_rd_data"},   {24'd0, rd_data},   32'd0);
    endtask

    initial begin
        logic [7:0] b55;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        t_start   = 0;
        lat_first = -1;
        rxd       = 1'b1;
        reset     = 1'b1;
        rd_en     = 1'b0;
        err_clr   = 1'b0;
        repeat (5) step();
        reset = 1'b0;
        step();
        check_reset_vals("reset");

        // 1: single byte, latency from the start edge, then pop
        send_frame(8'h34, 1'b1);
        exp_q.push_back(8'h34);
        checks++;
        assert (lat_first >= c_LAT - 1 && lat_first <= c_LAT + 1)
        else begin
            errors++;
            $error("FAIL latency observed=%0d expected=%0d+/-1", lat_first, c_LAT);
        end
        pop_check("t1_pop");
        check("t1_empty", {31'd0, rd_valid}, 32'd0);

        // 2: four back-to-back frames fill the FIFO
        send_frame(8'h34, 1'b1); exp_q.push_back(8'h34);
        send_frame(8'h2A, 1'b1); exp_q.push_back(8'h2A);
        send_frame(8'h34, 1'b1); exp_q.push_back(8'h34);
        send_frame(8'h39, 1'b1); exp_q.push_back(8'h39);
        check("t2_full",  {31'd0, fifo_full}, 32'd1);
        check("t2_valid", {31'd0, rd_valid},  32'd1);
        check("t2_no_ovr", {31'd0, overrun},  32'd0);

        // 3: overrun on a full FIFO, clear, then drain the untouched contents
        send_frame(8'h2F, 1'b1);
        check("t3_overrun", {31'd0, overrun},   32'd1);
        check("t3_full",    {31'd0, fifo_full}, 32'd1);
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t3_ovr_clr", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < FIFO_DEPTH; i++) pop_check("t3_pop");
        check("t3_empty",    {31'd0, rd_valid},  32'd0);
        check("t3_not_full", {31'd0, fifo_full}, 32'd0);
        check("t3_hold",     {24'd0, rd_data},   32'h39);

        // 4: short low glitch is rejected silently
        step();
        rxd = 1'b0;
        repeat (50) step();
        idle(3 * CLKS_PER_BIT);
        check("t4_no_push", {31'd0, rd_valid},  32'd0);
        check("t4_no_ferr", {31'd0, frame_err}, 32'd0);
        check("t4_no_ovr",  {31'd0, overrun},   32'd0);

        // 5: stop bit low -> framing error, nothing pushed
        send_frame(8'h30, 1'b0);
        idle(3 * CLKS_PER_BIT);
        check("t5_ferr",    {31'd0, frame_err}, 32'd1);
        check("t5_no_push", {31'd0, rd_valid},  32'd0);

        // 6: reset during data bit 4 of 0x55, then a clean frame
        b55 = 8'h55;
        step();
        rxd = 1'b0;
        repeat (CLKS_PER_BIT - 1) step();
        for (int i = 0; i < 4; i++) begin
            step();
            rxd = b55[i];
            repeat (CLKS_PER_BIT - 1) step();
        end
        step();
        rxd = b55[4];
        repeat (CLKS_PER_BIT / 2) step();
        reset = 1'b1;
        repeat (3) step();
        check_reset_vals("t6_rst");
        reset = 1'b0;
        idle(2 * CLKS_PER_BIT);
        check("t6_no_push", {31'd0, rd_valid}, 32'd0);
        send_frame(8'h30, 1'b1);
        exp_q.push_back(8'h30);
        pop_check("t6_pop");
        check("t6_empty", {31'd0, rd_valid},  32'd0);
        check("t6_ferr",  {31'd0, frame_err}, 32'd0);
        check("t6_sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
